// File: rtl/pio_arbiter.sv
// Round-robin arbiter sharing one PIO master port among NUM_REQ requesters.
// One transaction in flight; read responses are routed back to the issuing requester, with timeout.
module pio_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_cmd_vld,
  input  logic [NUM_REQ*16-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_data_w,
  input  logic [NUM_REQ-1:0]      req_rw,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [31:0]             req_data_r,
  output logic [NUM_REQ-1:0]      req_rd_vld,
  output logic [NUM_REQ-1:0]      req_rd_err,
  output logic                    pio_cmd_vld,
  output logic [15:0]             pio_addr,
  output logic [31:0]             pio_data_w,
  output logic                    pio_rw,
  input  logic [31:0]             pio_data_r,
  input  logic                    pio_rd_vld
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   last_g_reg;
  logic [IDX_W-1:0]   pick_next;
  logic [SUM_W-1:0]   sum_next;
  logic [TMR_W-1:0]   timer_reg;
  logic [15:0]        addr_arr  [NUM_REQ];
  logic [31:0]        wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[16*gi +: 16];
    assign wdata_arr[gi] = req_data_w[32*gi +: 32];
  end

  // Walk downward so the nearest set bit after last_g is the final assignment.
  always_comb begin
    pick_next = last_g_reg;
    sum_next  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum_next = {1'b0, last_g_reg} + SUM_W'(k);
      if (sum_next >= SUM_W'(NUM_REQ))
        sum_next = sum_next - SUM_W'(NUM_REQ);
      if (req_cmd_vld[sum_next[IDX_W-1:0]])
        pick_next = sum_next[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      last_g_reg  <= IDX_W'(NUM_REQ - 1);
      timer_reg   <= '0;
      req_ack     <= '0;
      req_data_r  <= '0;
      req_rd_vld  <= '0;
      req_rd_err  <= '0;
      pio_cmd_vld <= 1'b0;
      pio_addr    <= '0;
      pio_data_w  <= '0;
      pio_rw      <= 1'b0;
    end else begin
      req_ack     <= '0;
      req_rd_vld  <= '0;
      req_rd_err  <= '0;
      pio_cmd_vld <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req_cmd_vld) begin
            pio_cmd_vld         <= 1'b1;
            pio_addr            <= addr_arr[pick_next];
            pio_data_w          <= wdata_arr[pick_next];
            pio_rw              <= req_rw[pick_next];
            req_ack[pick_next]  <= 1'b1;
            last_g_reg          <= pick_next;
            state_reg           <= ISSUE;
          end
        end
        ISSUE: begin
          if (pio_rw) begin
            state_reg <= IDLE;
          end else begin
            timer_reg <= '0;
            state_reg <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Real data takes priority over a timeout decided in the same cycle.
          if (pio_rd_vld) begin
            req_data_r             <= pio_data_r;
            req_rd_vld[last_g_reg] <= 1'b1;
            state_reg              <= IDLE;
          end else if (timer_reg == TMR_LAST) begin
            req_data_r             <= ERR_DATA;
            req_rd_vld[last_g_reg] <= 1'b1;
            req_rd_err[last_g_reg] <= 1'b1;
            state_reg              <= IDLE;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_arbiter.sv
// Bench for pio_arbiter: directed vector table, hand sequences, and a randomized run
// against a transaction-level timing model.
module tb_pio_arbiter;

  localparam int          NR = 4;
  localparam int          T  = 8;
  localparam logic [31:0] ED = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_cmd_vld, req_rw, req_ack, req_rd_vld, req_rd_err;
  logic [NR*16-1:0] req_addr;
  logic [NR*32-1:0] req_data_w;
  logic [31:0]   req_data_r, pio_data_w, pio_data_r;
  logic          pio_cmd_vld, pio_rw, pio_rd_vld;
  logic [15:0]   pio_addr;

  pio_arbiter #(.NUM_REQ(NR), .TIMEOUT(T), .ERR_DATA(ED)) dut (
    .clk(clk), .reset(reset),
    .req_cmd_vld(req_cmd_vld), .req_addr(req_addr), .req_data_w(req_data_w), .req_rw(req_rw),
    .req_ack(req_ack), .req_data_r(req_data_r), .req_rd_vld(req_rd_vld), .req_rd_err(req_rd_err),
    .pio_cmd_vld(pio_cmd_vld), .pio_addr(pio_addr), .pio_data_w(pio_data_w), .pio_rw(pio_rw),
    .pio_data_r(pio_data_r), .pio_rd_vld(pio_rd_vld)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          who;
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          rsp_at;    // WAIT_RD cycle (1-based) in which the slave answers; 0 = never
    logic [31:0] rsp_data;
    int          exp_lat;   // cycles from ack to req_rd_vld; -1 = no response expected
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ack"}, 32'(req_ack), 32'h0);
    chk({tag, " rd_vld"}, 32'(req_rd_vld), 32'h0);
    chk({tag, " rd_err"}, 32'(req_rd_err), 32'h0);
    chk({tag, " data_r"}, req_data_r, 32'h0);
    chk({tag, " cmd_vld"}, 32'(pio_cmd_vld), 32'h0);
    chk({tag, " addr"}, 32'(pio_addr), 32'h0);
    chk({tag, " data_w"}, pio_data_w, 32'h0);
    chk({tag, " rw"}, 32'(pio_rw), 32'h0);
  endtask

  task automatic set_req(input int i, input logic vld, input logic rw,
                         input logic [15:0] a, input logic [31:0] d);
    req_cmd_vld[i]         = vld;
    req_rw[i]              = rw;
    req_addr[16*i +: 16]   = a;
    req_data_w[32*i +: 32] = d;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    set_req(v.who, 1'b1, v.rw, v.addr, v.wdata);
    pio_rd_vld = 1'b0;
    tick();
    chk("vec ack", 32'(req_ack), 32'(1 << v.who));
    chk("vec cmd_vld", 32'(pio_cmd_vld), 32'h1);
    chk("vec addr", 32'(pio_addr), 32'(v.addr));
    chk("vec rw", 32'(pio_rw), 32'(v.rw));
    if (v.rw) chk("vec data_w", pio_data_w, v.wdata);
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 1) begin
        req_cmd_vld[v.who] = 1'b0;
        chk("vec cmd_vld low", 32'(pio_cmd_vld), 32'h0);
        chk("vec ack low", 32'(req_ack), 32'h0);
      end
      pio_rd_vld = (j == v.rsp_at);
      pio_data_r = v.rsp_data;
      chk("vec rd_vld", 32'(req_rd_vld), (j == v.exp_lat) ? 32'(1 << v.who) : 32'h0);
      if (j == v.exp_lat) begin
        chk("vec data_r", req_data_r, v.exp_data);
        chk("vec rd_err", 32'(req_rd_err), v.exp_err ? 32'(1 << v.who) : 32'h0);
      end
    end
    pio_rd_vld = 1'b0;
    $display("vec %0d: req%0d rw=%0d addr=%h done", n, v.who, v.rw, v.addr);
  endtask

  task automatic run_random(input int ncyc);
    int free_at = 0, m_last = NR - 1, rd_vis_at = -1, rd_g = 0, rsp_drive_at = -1;
    int wait_lo = 1, wait_hi = 0, d, g, r, ntx = 0;
    logic        rd_err_m = 1'b0, e_cmd = 1'b0, e_rw = 1'b0;
    logic [31:0] rd_data_m = '0, rsp_val = '0, e_wd = '0, e_dr = '0;
    logic [15:0] e_addr = '0;
    logic [NR-1:0] e_ack = '0, e_rdv = '0, e_err = '0, prev_ack = '0;
    for (int c = 0; c < ncyc; c++) begin
      chk("rnd ack", 32'(req_ack), 32'(e_ack));
      chk("rnd cmd_vld", 32'(pio_cmd_vld), 32'(e_cmd));
      chk("rnd addr", 32'(pio_addr), 32'(e_addr));
      chk("rnd data_w", pio_data_w, e_wd);
      chk("rnd rw", 32'(pio_rw), 32'(e_rw));
      chk("rnd rd_vld", 32'(req_rd_vld), 32'(e_rdv));
      chk("rnd rd_err", 32'(req_rd_err), 32'(e_err));
      chk("rnd data_r", req_data_r, e_dr);
      // Requesters: acked ones may change the cycle after ack; idle ones may raise a request.
      for (int i = 0; i < NR; i++) begin
        if (prev_ack[i] || !req_cmd_vld[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
          else if (prev_ack[i])
            req_cmd_vld[i] = 1'b0;
        end
      end
      prev_ack = e_ack;
      // Slave: scheduled answer, otherwise occasional stray valid outside the wait window.
      if (c == rsp_drive_at) begin
        pio_rd_vld = 1'b1;
        pio_data_r = rsp_val;
      end else if ((c < wait_lo || c > wait_hi) && $urandom_range(0, 7) == 0) begin
        pio_rd_vld = 1'b1;
        pio_data_r = $urandom;
      end else begin
        pio_rd_vld = 1'b0;
        pio_data_r = $urandom;
      end
      // Expected outputs for the next cycle.
      e_ack = '0; e_cmd = 1'b0; e_rdv = '0; e_err = '0;
      if (c >= free_at && req_cmd_vld != '0) begin
        g = -1;
        for (int k = 1; k <= NR; k++)
          if (g < 0 && req_cmd_vld[(m_last + k) % NR]) g = (m_last + k) % NR;
        m_last   = g;
        e_ack[g] = 1'b1;
        e_cmd    = 1'b1;
        e_addr   = req_addr[16*g +: 16];
        e_wd     = req_data_w[32*g +: 32];
        e_rw     = req_rw[g];
        ntx++;
        if (e_rw) begin
          free_at = c + 2;
          $display("rnd txn %0d: req%0d write addr=%h data=%h", ntx, g, e_addr, e_wd);
        end else begin
          r = int'($urandom_range(0, 9));
          if (r < 6)      d = int'($urandom_range(1, T));
          else if (r < 8) d = T;
          else            d = T + 1 + int'($urandom_range(0, 1));
          rsp_val      = $urandom;
          rsp_drive_at = c + 1 + d;
          wait_lo      = c + 2;
          wait_hi      = c + 1 + ((d <= T) ? d : T);
          if (d <= T) begin
            rd_vis_at = c + 2 + d; rd_data_m = rsp_val; rd_err_m = 1'b0;
          end else begin
            rd_vis_at = c + 2 + T; rd_data_m = ED;      rd_err_m = 1'b1;
          end
          rd_g    = g;
          free_at = rd_vis_at;
          $display("rnd txn %0d: req%0d read addr=%h slave_delay=%0d", ntx, g, e_addr, d);
        end
      end
      if (c + 1 == rd_vis_at) begin
        e_rdv[rd_g] = 1'b1;
        e_err[rd_g] = rd_err_m;
        e_dr        = rd_data_m;
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 1'b1, 16'h0010, 32'h1234_5678, 0, 32'h0,         -1, 32'h0,         1'b0};
    vecs[1] = '{2, 1'b0, 16'h0040, 32'h0,         5, 32'hCAFE_F00D,  6, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{3, 1'b0, 16'h0080, 32'h0,         0, 32'h0,          9, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{0, 1'b0, 16'h1234, 32'h0,         8, 32'h0000_0055,  9, 32'h0000_0055, 1'b0};
    vecs[4] = '{2, 1'b0, 16'hFFFF, 32'h0,         1, 32'hA5A5_A5A5,  2, 32'hA5A5_A5A5, 1'b0};
    vecs[5] = '{3, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 0, 32'h0,         -1, 32'h0,         1'b0};

    reset = 1'b0; req_cmd_vld = '0; req_rw = '0; req_addr = '0; req_data_w = '0;
    pio_rd_vld = 1'b0; pio_data_r = '0;
    tick(); tick();
    chk_zero("reset");
    $display("reset: outputs checked");
    reset = 1'b1;
    tick();

    for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

    // Stray pio_rd_vld while idle: no response, data_r holds.
    pio_rd_vld = 1'b1; pio_data_r = 32'h0000_0077;
    tick();
    pio_rd_vld = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk("stray rd_vld", 32'(req_rd_vld), 32'h0);
      chk("stray data_r", req_data_r, 32'hA5A5_A5A5);
      tick();
    end
    $display("stray idle: checked");

    // Rotation: all four write, req0 re-requests after its grant.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 16'(16'h0100 * (i + 1)), 32'h1000 + i);
    for (int j = 1; j <= 11; j++) begin
      logic [3:0] ea;
      tick();
      ea = (j == 1) ? 4'b0001 : (j == 3) ? 4'b0010 : (j == 5) ? 4'b0100 :
           (j == 7) ? 4'b1000 : (j == 9) ? 4'b0001 : 4'b0000;
      chk("rot ack", 32'(req_ack), 32'(ea));
      chk("rot cmd_vld", 32'(pio_cmd_vld), 32'(ea != 0));
      if (j == 9) chk("rot addr", 32'(pio_addr), 32'h0A00);
      else if (ea != 0) chk("rot addr", 32'(pio_addr), 32'h0100 * (j / 2 + 1));
      if (j == 2)  set_req(0, 1'b1, 1'b1, 16'h0A00, 32'hA0A0_A0A0);
      if (j == 4)  req_cmd_vld[1] = 1'b0;
      if (j == 6)  req_cmd_vld[2] = 1'b0;
      if (j == 8)  req_cmd_vld[3] = 1'b0;
      if (j == 10) req_cmd_vld[0] = 1'b0;
    end
    $display("rotation: grants 0,1,2,3,0 checked");

    // Read by req2 with req0 waiting behind it.
    set_req(2, 1'b1, 1'b0, 16'h0040, 32'h0);
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("rdq ack", 32'(req_ack), (j == 1) ? 32'h4 : (j == 8) ? 32'h1 : 32'h0);
      if (j == 1) set_req(0, 1'b1, 1'b1, 16'h0B00, 32'hB0B0_B0B0);
      if (j == 2) req_cmd_vld[2] = 1'b0;
      if (j == 9) req_cmd_vld[0] = 1'b0;
      pio_rd_vld = (j == 6);
      pio_data_r = 32'hCAFE_F00D;
      chk("rdq rd_vld", 32'(req_rd_vld), (j == 7) ? 32'h4 : 32'h0);
      if (j == 7) begin
        chk("rdq data_r", req_data_r, 32'hCAFE_F00D);
        chk("rdq rd_err", 32'(req_rd_err), 32'h0);
      end
    end
    pio_rd_vld = 1'b0;
    $display("read with pending req0: checked");

    // Reset during WAIT_RD drops the read; late slave data is stray.
    set_req(1, 1'b1, 1'b0, 16'h0200, 32'h0);
    tick();
    chk("rst ack", 32'(req_ack), 32'h2);
    tick();
    req_cmd_vld[1] = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk_zero("mid reset");
    reset = 1'b1;
    tick();
    pio_rd_vld = 1'b1; pio_data_r = 32'h0000_0099;
    tick();
    pio_rd_vld = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk("post-rst rd_vld", 32'(req_rd_vld), 32'h0);
      chk("post-rst data_r", req_data_r, 32'h0);
      tick();
    end
    set_req(0, 1'b1, 1'b1, 16'h0300, 32'h3333_3333);
    set_req(2, 1'b1, 1'b1, 16'h0400, 32'h4444_4444);
    tick();
    chk("post-rst ack0", 32'(req_ack), 32'h1);
    chk("post-rst addr0", 32'(pio_addr), 32'h0300);
    tick();
    req_cmd_vld[0] = 1'b0;
    chk("post-rst gap", 32'(req_ack), 32'h0);
    tick();
    chk("post-rst ack2", 32'(req_ack), 32'h4);
    chk("post-rst addr2", 32'(pio_addr), 32'h0400);
    tick();
    req_cmd_vld[2] = 1'b0;
    tick();
    $display("reset mid-read: checked");

    // Randomized run from a fresh reset.
    req_cmd_vld = '0; pio_rd_vld = 1'b0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    run_random(1200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_arbiter.md
Name: pio_arbiter

Overview:
Shares one PIO master port among NUM_REQ requesters using round-robin arbitration. Allows one outstanding transaction at a time. Routes each read response back to the requester that issued it, and returns an error response if the slave never answers a read. Sits between the requester blocks (CPU model, DMA, debug) and the single PIO slave bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 255, WAIT_RD cycles before a read is aborted (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-low reset
req_cmd_vld  input  NUM_REQ  per-requester command valid; held until matching req_ack
req_addr  input  NUM_REQ*16  per-requester address, requester i at [16*i +: 16]
req_data_w  input  NUM_REQ*32  per-requester write data, [32*i +: 32]
req_rw  input  NUM_REQ  per-requester 0-read, 1-write
req_ack  output  NUM_REQ  one-cycle pulse: command issued on PIO
req_data_r  output  32  read data, shared by all requesters
req_rd_vld  output  NUM_REQ  one-cycle pulse: req_data_r valid for requester i
req_rd_err  output  NUM_REQ  asserted together with req_rd_vld[i] on timeout
pio_cmd_vld  output  1  PIO command valid
pio_addr  output  16  PIO address
pio_data_w  output  32  PIO write data
pio_rw  output  1  PIO 0-read, 1-write
pio_data_r  input  32  PIO read data
pio_rd_vld  input  1  PIO read data valid

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low.
- All outputs are registered.
- Reset (reset==0 at posedge):
  - State goes to IDLE; timer is 0.
  - grant pointer last_g = NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0.
- State machine (IDLE, ISSUE, WAIT_RD).
- IDLE:
  - If any req_cmd_vld is set, pick g = first set bit searching from last_g+1 with wrap-around.
  - Register req_addr/req_data_w/req_rw of g into the pio_* output registers; set pio_cmd_vld=1 and req_ack[g]=1.
  - last_g <= g; go to ISSUE.
- ISSUE (exactly one cycle):
  - pio_cmd_vld and req_ack[g] are high in this cycle only.
  - Write: go to IDLE.
  - Read: clear timer and go to WAIT_RD.
- WAIT_RD:
  - pio_cmd_vld=0.
  - If pio_rd_vld: req_data_r <= pio_data_r, req_rd_vld[g] pulses next cycle with err=0; go to IDLE.
  - Else if timer==TIMEOUT-1: req_data_r <= ERR_DATA, req_rd_vld[g] and req_rd_err[g] pulse next cycle; go to IDLE.
  - Else timer increments.
- Latency:
  - Request sampled in IDLE at cycle t -> pio_cmd_vld/req_ack at t+1.
  - pio_rd_vld at cycle r -> req_rd_vld at r+1.
  - Back-to-back writes issue at most every 2 cycles.
- Hold rules:
  - Requesters drop or change req_cmd_vld the cycle after ack.
  - Non-granted requests stay pending, unmodified, while the arbiter is busy.
- After issue, pio_addr/pio_data_w/pio_rw hold their last values; only pio_cmd_vld qualifies them.
- req_data_r holds its value until the next response.
- Simultaneous events:
  - pio_rd_vld in the timeout cycle: real data wins, err=0.
  - pio_rd_vld in IDLE or ISSUE is stray: ignored, no output.
- Reset mid-operation:
  - A pending read is dropped with no response.
  - A pio_rd_vld arriving after reset is ignored as stray.
- Timer width is $clog2(TIMEOUT+1); the timer never wraps.

Test Plan:
- Req1 write addr 0x0010 data 0x12345678 -> one cycle later pio_cmd_vld=1, rw=1, addr 0x0010, data 0x12345678, req_ack[1]=1 for 1 cycle; no req_rd_vld.
- Req0-3 all write, held until acked -> grants in order 0,1,2,3, pio_cmd_vld every 2nd cycle; req0 then re-requests -> granted after req3, confirming rotation.
- Req2 read addr 0x0040, slave asserts pio_rd_vld with 0xCAFEF00D 5 cycles after issue; req0 requests meanwhile -> req_rd_vld[2]=1 one cycle after, data 0xCAFEF00D, err 0; req0 issued only after that.
- TIMEOUT=8, req3 read, no slave response -> on the 8th WAIT_RD cycle the decision is made; next cycle req_rd_vld[3]=1, req_rd_err[3]=1, data 0xDEADBEEF.
- TIMEOUT=8, pio_rd_vld with 0x00000055 exactly in the 8th WAIT_RD cycle -> data 0x00000055, err=0; stray pio_rd_vld in IDLE -> no output.
- reset=0 for 1 cycle during WAIT_RD -> all outputs 0; a later pio_rd_vld gives no response; next simultaneous req0/req2 requests -> req0 granted first.
